// File: rtl/rf_wb_pkg.sv
// Shared constants, typedefs and the round-robin pick for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int NUM_REQ       = 2;
    localparam int REQ_ALU       = 0;
    localparam int REQ_LSU       = 1;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

    // A tie goes to the requester that did not win last time.
    function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] valid,
                                                   input logic                last_grant);
        logic [NUM_REQ-1:0] gnt;
        gnt = '0;
        case (valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rf_wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module rf_wb_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_AMOUNT = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    output logic                  o_issue_ready,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addrA,
    input  logic [ADDR_WIDTH-1:0] i_rd_addrB,
    output logic                  o_busyA,
    output logic                  o_busyB
);

    localparam logic [REG_AMOUNT-1:0] KEEP_MASK = {{(REG_AMOUNT-1){1'b1}}, 1'b0};

    logic [REG_AMOUNT-1:0] pending;
    logic [REG_AMOUNT-1:0] set_vec;
    logic [REG_AMOUNT-1:0] clr_vec;

    assign o_issue_ready = !i_issue_valid || (i_issue_rd == '0) || !pending[i_issue_rd];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (i_issue_valid && o_issue_ready && (i_issue_rd != '0))
            set_vec[i_issue_rd] = 1'b1;
        if (i_clr_en)
            clr_vec[i_clr_addr] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            pending <= '0;
        else
            pending <= ((pending & ~clr_vec) | set_vec) & KEEP_MASK;
    end

    assign o_busyA = pending[i_rd_addrA];
    assign o_busyB = pending[i_rd_addrB];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port plus pending-write scoreboard.
// Define RF_WB_BYPASS_EN to add forwarding of the registered write to the decode read ports.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int REG_AMOUNT = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_issue_valid,
    input  logic [ADDR_WIDTH-1:0]         i_issue_rd,
    output logic                          o_issue_ready,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_w_enable,
    output logic [ADDR_WIDTH-1:0]         o_w_addr,
    output logic [DATA_WIDTH-1:0]         o_w_data,
`ifdef RF_WB_BYPASS_EN
    output logic                          o_fwdA_valid,
    output logic                          o_fwdB_valid,
    output logic [DATA_WIDTH-1:0]         o_fwdA_data,
    output logic [DATA_WIDTH-1:0]         o_fwdB_data,
`endif
    input  logic [ADDR_WIDTH-1:0]         i_rd_addrA,
    input  logic [ADDR_WIDTH-1:0]         i_rd_addrB,
    output logic                          o_busyA,
    output logic                          o_busyB
);

    logic [NUM_REQ-1:0]    gnt;
    logic                  last_grant;
    logic                  hs;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sb_busyA;
    logic                  sb_busyB;

    assign gnt         = rr_grant(i_req_valid, last_grant);
    assign o_req_ready = gnt;
    assign hs          = |gnt;
    assign sel         = gnt[REQ_LSU];
    assign sel_addr    = sel ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH] : i_req_addr[0 +: ADDR_WIDTH];
    assign sel_data    = sel ? i_req_data[DATA_WIDTH +: DATA_WIDTH] : i_req_data[0 +: DATA_WIDTH];

    // Writes to register 0 are accepted and dropped here; addr/data still follow the handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
            o_w_enable <= 1'b0;
            o_w_addr   <= '0;
            o_w_data   <= '0;
        end else begin
            o_w_enable <= hs && (sel_addr != '0);
            if (hs) begin
                last_grant <= sel;
                o_w_addr   <= sel_addr;
                o_w_data   <= sel_data;
            end
        end
    end

    rf_wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_AMOUNT (REG_AMOUNT)
    ) u_sb (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_ready (o_issue_ready),
        .i_clr_en      (o_w_enable),
        .i_clr_addr    (o_w_addr),
        .i_rd_addrA    (i_rd_addrA),
        .i_rd_addrB    (i_rd_addrB),
        .o_busyA       (sb_busyA),
        .o_busyB       (sb_busyB)
    );

`ifdef RF_WB_BYPASS_EN
    // o_w_enable already implies a nonzero o_w_addr, so register 0 never forwards.
    assign o_fwdA_valid = o_w_enable && (o_w_addr == i_rd_addrA);
    assign o_fwdB_valid = o_w_enable && (o_w_addr == i_rd_addrB);
    assign o_fwdA_data  = o_w_data;
    assign o_fwdB_data  = o_w_data;
    assign o_busyA      = sb_busyA && !o_fwdA_valid;
    assign o_busyB      = sb_busyB && !o_fwdB_valid;
`else
    assign o_busyA      = sb_busyA;
    assign o_busyB      = sb_busyB;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, output stage, scoreboard, register 0, reset.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_issue_valid;
    logic [AW-1:0] i_issue_rd;
    logic          o_issue_ready;
    logic [1:0]    i_req_valid;
    logic [2*AW-1:0] i_req_addr;
    logic [2*DW-1:0] i_req_data;
    logic [1:0]    o_req_ready;
    logic          o_w_enable;
    logic [AW-1:0] o_w_addr;
    logic [DW-1:0] o_w_data;
    logic [AW-1:0] i_rd_addrA;
    logic [AW-1:0] i_rd_addrB;
    logic          o_busyA;
    logic          o_busyB;
`ifdef RF_WB_BYPASS_EN
    logic          o_fwdA_valid;
    logic          o_fwdB_valid;
    logic [DW-1:0] o_fwdA_data;
    logic [DW-1:0] o_fwdB_data;
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int ai;
    int li;
    int exp_a [8] = '{11, 1, 12, 2, 13, 3, 14, 4};
    logic [1:0] exp_g [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    rf_wb_arbiter dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_ready (o_issue_ready),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_req_ready   (o_req_ready),
        .o_w_enable    (o_w_enable),
        .o_w_addr      (o_w_addr),
        .o_w_data      (o_w_data),
`ifdef RF_WB_BYPASS_EN
        .o_fwdA_valid  (o_fwdA_valid),
        .o_fwdB_valid  (o_fwdB_valid),
        .o_fwdA_data   (o_fwdA_data),
        .o_fwdB_data   (o_fwdB_data),
`endif
        .i_rd_addrA    (i_rd_addrA),
        .i_rd_addrB    (i_rd_addrB),
        .o_busyA       (o_busyA),
        .o_busyB       (o_busyB)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        i_req_valid = v;
        i_req_addr  = {a1, a0};
        i_req_data  = {d1, d0};
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_issue_valid = 1'b0;
        i_issue_rd = '0;
        i_rd_addrA = '0;
        i_rd_addrB = '0;
        drive_req(2'b00, 0, 0, 0, 0);
        #2;
        chk("rst_w_enable", o_w_enable, 0);
        chk("rst_w_addr", o_w_addr, 0);
        chk("rst_w_data", o_w_data, 0);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_issue_ready", o_issue_ready, 1);
        tick();
        tick();
        i_rst_n = 1'b1;

        // Single ALU write.
        drive_req(2'b01, 5, 32'hAA, 0, 0);
        #1 chk("alu_ready", o_req_ready, 2'b01);
        tick();
        i_req_valid = 2'b00;
        #1;
        chk("alu_w_en", o_w_enable, 1);
        chk("alu_w_addr", o_w_addr, 5);
        chk("alu_w_data", o_w_data, 32'hAA);
        tick();
        chk("idle_w_en", o_w_enable, 0);
        chk("idle_addr_hold", o_w_addr, 5);

        // Contention: ALU won last, so LSU goes first, then strict alternation.
        ai = 0;
        li = 0;
        for (int c = 0; c < 8; c++) begin
            drive_req({li < 4, ai < 4}, AW'(1 + ai), DW'(32'h100 + 1 + ai),
                      AW'(11 + li), DW'(32'h100 + 11 + li));
            #1;
            chk("rr_grant", o_req_ready, exp_g[c]);
            if (c > 0) begin
                chk("rr_w_en", o_w_enable, 1);
                chk("rr_w_addr", o_w_addr, exp_a[c-1]);
                chk("rr_w_data", o_w_data, 32'h100 + exp_a[c-1]);
            end
            if (exp_g[c][0]) ai++;
            else li++;
            tick();
        end
        i_req_valid = 2'b00;
        #1;
        chk("rr_last_w_en", o_w_enable, 1);
        chk("rr_last_addr", o_w_addr, 4);
        chk("rr_last_data", o_w_data, 32'h104);
        tick();
        chk("rr_drain", o_w_enable, 0);

        // Issue rd=7, WAW refusal, clear on writeback.
        i_issue_valid = 1'b1;
        i_issue_rd = 7;
        i_rd_addrA = 7;
        #1;
        chk("iss7_ready", o_issue_ready, 1);
        chk("iss7_busy_before", o_busyA, 0);
        tick();
        chk("waw_refused", o_issue_ready, 0);
        chk("busy7", o_busyA, 1);
        i_issue_valid = 1'b0;
        drive_req(2'b01, 7, 32'h77, 0, 0);
        #1 chk("wb7_ready", o_req_ready, 2'b01);
        tick();
        i_req_valid = 2'b00;
        #1;
        chk("wb7_w_en", o_w_enable, 1);
        chk("wb7_w_addr", o_w_addr, 7);
        chk("busy7_write_cycle", o_busyA, !BYP);
        tick();
        chk("busy7_cleared", o_busyA, 0);
        i_issue_valid = 1'b1;
        #1 chk("reissue7_ready", o_issue_ready, 1);
        i_issue_valid = 1'b0;

        // Write to non-pending reg 3 lands on the same edge as issue of rd=3: set wins.
        drive_req(2'b01, 3, 32'h33, 0, 0);
        #1 chk("wb3_ready", o_req_ready, 2'b01);
        tick();
        i_req_valid = 2'b00;
        i_issue_valid = 1'b1;
        i_issue_rd = 3;
        i_rd_addrA = 3;
        #1;
        chk("iss3_ready", o_issue_ready, 1);
        chk("wb3_w_en", o_w_enable, 1);
        chk("wb3_w_addr", o_w_addr, 3);
        tick();
        i_issue_valid = 1'b0;
        #1;
        chk("set_wins_busy3", o_busyA, 1);
        chk("set_wins_w_en", o_w_enable, 0);

        // Register 0: accepted, never written, never busy.
        drive_req(2'b10, 0, 0, 0, 32'hFFFF_FFFF);
        #1 chk("r0_ready", o_req_ready, 2'b10);
        tick();
        i_req_valid = 2'b00;
        #1 chk("r0_no_write", o_w_enable, 0);
        i_issue_valid = 1'b1;
        i_issue_rd = 0;
        i_rd_addrA = 0;
        #1;
        chk("r0_issue_ready", o_issue_ready, 1);
        chk("r0_busy", o_busyA, 0);
        tick();
        i_issue_valid = 1'b0;
        #1 chk("r0_busy_after", o_busyA, 0);

        // Pend 8 and 9 (3 already pending), write to 9 in flight, then reset.
        i_issue_valid = 1'b1;
        i_issue_rd = 8;
        tick();
        i_issue_rd = 9;
        tick();
        i_issue_valid = 1'b0;
        drive_req(2'b01, 9, 32'h99, 0, 0);
        tick();
        i_req_valid = 2'b00;
        i_rd_addrA = 8;
        i_rd_addrB = 9;
        #1;
        chk("wb9_w_en", o_w_enable, 1);
        chk("wb9_w_addr", o_w_addr, 9);
        chk("busy8", o_busyA, 1);
        chk("busy9_write_cycle", o_busyB, !BYP);
`ifdef RF_WB_BYPASS_EN
        chk("fwdB_valid", o_fwdB_valid, 1);
        chk("fwdB_data", o_fwdB_data, 32'h99);
        chk("fwdA_valid", o_fwdA_valid, 0);
`endif
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en", o_w_enable, 0);
        chk("mid_rst_busyA8", o_busyA, 0);
        chk("mid_rst_busyB9", o_busyB, 0);
        i_rd_addrA = 3;
        #1 chk("mid_rst_busy3", o_busyA, 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        drive_req(2'b11, 1, 32'h1, 2, 32'h2);
        #1 chk("post_rst_tie_alu", o_req_ready, 2'b01);
        i_req_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
